duck_motion_ctrl: RTL

//  Per-duck motion/animation controller; directly upstream of the duck sprite renderer.

---
 rtl/duck_pkg.sv | 53 +++++
 rtl/duck_lfsr.sv | 25 ++
 rtl/duck_motion_ctrl.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/duck_pkg.sv
// Shared types, screen defaults and the axis stepping helper for the duck motion controller.
// The optional LFSR direction randomiser is enabled by defining DUCK_LFSR_EN.
package duck_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FLY,
    HIT,
    FALL,
    ESCAPE
  } duck_state_e;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;
  localparam logic DIR_UP    = 1'b0;
  localparam logic DIR_DOWN  = 1'b1;

  localparam int DUCK_H_RES    = 640;
  localparam int DUCK_V_RES    = 480;
  localparam int DUCK_SPRITE_W = 64;
  localparam int DUCK_SPRITE_H = 64;

  localparam logic [1:0] ANIM_REST = 2'd0;
  localparam logic [1:0] ANIM_SHOT = 2'd3;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef struct packed {
    logic [9:0] pos;
    logic       flip;
  } axis_step_t;

  // Touching either wall saturates there and reports a bounce, so the reversed move starts next frame.
  function automatic axis_step_t axis_step(input logic [9:0] pos, input logic inc,
                                           input logic [9:0] step, input logic [9:0] lim);
    logic signed [10:0] nxt;
    axis_step_t         r;
    nxt    = inc ? ($signed({1'b0, pos}) + $signed({1'b0, step}))
                 : ($signed({1'b0, pos}) - $signed({1'b0, step}));
    r.pos  = nxt[9:0];
    r.flip = 1'b0;
    if (nxt <= 11'sd0) begin
      r.pos  = '0;
      r.flip = 1'b1;
    end else if (nxt >= $signed({1'b0, lim})) begin
      r.pos  = lim;
      r.flip = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/duck_lfsr.sv
// 16-bit Galois LFSR advanced once per enable pulse; only built when DUCK_LFSR_EN is defined.
module duck_lfsr
  import duck_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic [1:0] rnd
);

  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (en) lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= LFSR_SEED;
    else        lfsr_q <= lfsr_d;
  end

  assign rnd = lfsr_q[1:0];

endmodule

// File: rtl/duck_motion_ctrl.sv
// Per-duck position, direction, flap animation and fly/hit/fall/escape life cycle, one step per frame.
// Define DUCK_LFSR_EN to randomise spawn direction and vertical heading on horizontal wall bounces.
module duck_motion_ctrl
  import duck_pkg::*;
#(
  parameter int H_RES         = DUCK_H_RES,
  parameter int V_RES         = DUCK_V_RES,
  parameter int SPRITE_W      = DUCK_SPRITE_W,
  parameter int SPRITE_H      = DUCK_SPRITE_H,
  parameter int STEP_X        = 2,
  parameter int STEP_Y        = 1,
  parameter int FALL_STEP     = 4,
  parameter int ESC_STEP      = 2,
  parameter int FLAP_DIV      = 8,
  parameter int HIT_HOLD      = 30,
  parameter int ESCAPE_FRAMES = 600
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  input  logic       frame_tick,
  input  logic       spawn,
  input  logic [9:0] spawn_x,
  input  logic       spawn_dir,
  input  logic       hit,
  output logic [9:0] duck_x,
  output logic [9:0] duck_y,
  output logic [1:0] anim_frame,
  output logic       visible,
  output logic       fallen,
  output logic       escaped
);

  localparam logic [9:0] XMAX = 10'(H_RES - SPRITE_W);
  localparam logic [9:0] YMAX = 10'(V_RES - SPRITE_H);
  localparam int FLAP_W = $clog2(FLAP_DIV + 1);
  localparam int ESC_W  = $clog2(ESCAPE_FRAMES + 1);
  localparam int HOLD_W = $clog2(HIT_HOLD + 1);

  duck_state_e       state_q, state_d;
  logic [9:0]        x_q, x_d, y_q, y_d;
  logic              dir_x_q, dir_x_d, dir_y_q, dir_y_d;
  logic [FLAP_W-1:0] flap_q, flap_d, flap_nxt;
  logic [ESC_W-1:0]  esc_q, esc_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [1:0]        anim_q, anim_d, anim_nxt;
  logic              visible_q, visible_d, fallen_q, fallen_d, escaped_q, escaped_d;
  logic              flap_wrap;
  axis_step_t        xs, ys, fs, es;
  logic [1:0]        lfsr_bits;

`ifdef DUCK_LFSR_EN
  localparam bit LFSR_EN = 1'b1;
  duck_lfsr u_lfsr (
    .clk   (vga_clk),
    .rst_n (reset_n),
    .en    (frame_tick),
    .rnd   (lfsr_bits)
  );
`else
  localparam bit LFSR_EN = 1'b0;
  assign lfsr_bits = 2'b00;
`endif

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    dir_x_d   = dir_x_q;
    dir_y_d   = dir_y_q;
    flap_d    = flap_q;
    esc_d     = esc_q;
    hold_d    = hold_q;
    anim_d    = anim_q;
    fallen_d  = 1'b0;
    escaped_d = 1'b0;

    xs = axis_step(x_q, dir_x_q == DIR_RIGHT, 10'(STEP_X), XMAX);
    ys = axis_step(y_q, dir_y_q == DIR_DOWN, 10'(STEP_Y), YMAX);
    fs = axis_step(y_q, 1'b1, 10'(FALL_STEP), YMAX);
    es = axis_step(y_q, 1'b0, 10'(ESC_STEP), YMAX);

    flap_wrap = (flap_q == FLAP_W'(FLAP_DIV - 1));
    flap_nxt  = flap_wrap ? '0 : flap_q + 1'b1;
    anim_nxt  = anim_q;
    if (flap_wrap) anim_nxt = (anim_q >= 2'd2) ? 2'd0 : anim_q + 2'd1;

    unique case (state_q)
      IDLE: begin
        if (spawn) begin
          state_d = FLY;
          x_d     = (spawn_x > XMAX) ? XMAX : spawn_x;
          y_d     = YMAX;
          dir_x_d = spawn_dir ^ lfsr_bits[1];
          dir_y_d = DIR_UP;
          flap_d  = '0;
          esc_d   = '0;
          anim_d  = ANIM_REST;
        end
      end
      FLY: begin
        // A shot wins over both the frame move and an escape expiry in the same cycle.
        if (hit) begin
          state_d = HIT;
          anim_d  = ANIM_SHOT;
          hold_d  = '0;
        end else if (frame_tick) begin
          x_d = xs.pos;
          y_d = ys.pos;
          if (xs.flip) dir_x_d = ~dir_x_q;
          if (ys.flip) dir_y_d = ~dir_y_q;
          if (LFSR_EN && xs.flip) dir_y_d = lfsr_bits[0];
          flap_d = flap_nxt;
          anim_d = anim_nxt;
          esc_d  = esc_q + 1'b1;
          if (esc_q == ESC_W'(ESCAPE_FRAMES - 1)) state_d = ESCAPE;
        end
      end
      HIT: begin
        if (frame_tick) begin
          hold_d = hold_q + 1'b1;
          if (hold_q == HOLD_W'(HIT_HOLD - 1)) state_d = FALL;
        end
      end
      FALL: begin
        if (frame_tick) begin
          y_d    = fs.pos;
          anim_d = ANIM_SHOT;
          if (fs.flip) begin
            fallen_d = 1'b1;
            state_d  = IDLE;
          end
        end
      end
      ESCAPE: begin
        if (frame_tick) begin
          y_d = es.pos;
          x_d = xs.pos;
          if (xs.flip) dir_x_d = ~dir_x_q;
          flap_d = flap_nxt;
          anim_d = anim_nxt;
          if (es.flip) begin
            escaped_d = 1'b1;
            state_d   = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    visible_d = (state_d != IDLE);
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      x_q       <= '0;
      y_q       <= YMAX;
      dir_x_q   <= DIR_RIGHT;
      dir_y_q   <= DIR_UP;
      flap_q    <= '0;
      esc_q     <= '0;
      hold_q    <= '0;
      anim_q    <= ANIM_REST;
      visible_q <= 1'b0;
      fallen_q  <= 1'b0;
      escaped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      dir_x_q   <= dir_x_d;
      dir_y_q   <= dir_y_d;
      flap_q    <= flap_d;
      esc_q     <= esc_d;
      hold_q    <= hold_d;
      anim_q    <= anim_d;
      visible_q <= visible_d;
      fallen_q  <= fallen_d;
      escaped_q <= escaped_d;
    end
  end

  assign duck_x     = x_q;
  assign duck_y     = y_q;
  assign anim_frame = anim_q;
  assign visible    = visible_q;
  assign fallen     = fallen_q;
  assign escaped    = escaped_q;

endmodule
